// File: rtl/p2s_load_scheduler.sv
// Round-robin load scheduler for a shared parallel-to-serial converter.
// Define P2S_BACK_TO_BACK_EN to allow a grant on the last SHIFT cycle.
module p2s_load_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int SERIAL_LEN = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       load,
  output logic [7:0]                 parallel_in,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(SERIAL_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SERIAL_LEN - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
  localparam logic [IW:0]   NREQ_W   = (IW+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [7:0]    data_q, data_d;

  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;
  logic [7:0]    win_data;
  logic          shift_last;
  logic          grant_ok;
  logic          grant;

  // Search starts just past the last winner, wrapping around.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, last_q} + (IW+1)'(k);
      if (sum >= NREQ_W) begin
        sum = sum - NREQ_W;
      end
      idx = sum[IW-1:0];
      if (!win_vld && req_valid[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  assign win_data = req_data[{win_idx, 3'b000} +: 8];

  assign shift_last = (state_q == S_SHIFT)
                   && (cnt_q == CNT_LAST);

`ifdef P2S_BACK_TO_BACK_EN
  assign grant_ok = (state_q == S_IDLE) || shift_last;
`else
  assign grant_ok = (state_q == S_IDLE);
`endif

  // Reset gates the grant so nothing is consumed while held in reset.
  assign grant = grant_ok && win_vld && !rst;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gidx_d  = gidx_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (shift_last) begin
          state_d = grant ? S_LOAD : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (grant) begin
      data_d = win_data;
      gidx_d = win_idx;
      last_d = win_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= LAST_RST;
      gidx_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      data_q  <= data_d;
    end
  end

  assign load        = (state_q == S_LOAD);
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = shift_last;
  assign parallel_in = data_q;
  assign grant_idx   = gidx_q;

endmodule

// File: tb/tb_p2s_load_scheduler.sv
// Bench for p2s_load_scheduler: cycle model plus directed scenarios.
// Honours P2S_BACK_TO_BACK_EN for expected frame spacing.
module tb_p2s_load_scheduler;

  localparam int NR = 4;
  localparam int SL = 8;
`ifdef P2S_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          load, busy, frame_done;
  logic [7:0]    parallel_in;
  logic [1:0]    grant_idx;

  logic [1:0]    v2;
  logic [15:0]   d2;
  logic [1:0]    rdy2;
  logic          load2, busy2, fd2;
  logic [7:0]    pin2;
  logic          gidx2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  p2s_load_scheduler #(.NUM_REQ(NR), .SERIAL_LEN(SL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .load(load),
    .parallel_in(parallel_in), .grant_idx(grant_idx),
    .busy(busy), .frame_done(frame_done)
  );

  p2s_load_scheduler #(.NUM_REQ(2), .SERIAL_LEN(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(v2), .req_data(d2),
    .req_ready(rdy2), .load(load2),
    .parallel_in(pin2), .grant_idx(gidx2),
    .busy(busy2), .frame_done(fd2)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Model: frame position counted in cycles since the grant.
  int m_pos, m_last, m_gidx, win;
  logic [7:0] m_data;
  logic [NR-1:0] e_rdy;
  bit can;

  always @(negedge clk) begin
    if (rst) begin
      m_pos = 0; m_last = NR - 1;
      m_gidx = 0; m_data = 8'h00;
    end
    can = !rst && (m_pos == 0 || (B2B && m_pos == SL + 1));
    win = -1;
    for (int k = 1; k <= NR; k++) begin
      int ix;
      ix = (m_last + k) % NR;
      if (win < 0 && req_valid[ix]) win = ix;
    end
    e_rdy = '0;
    if (can && win >= 0) e_rdy[win] = 1'b1;
    chk("m_ready", 32'(req_ready), 32'(e_rdy));
    chk("m_load", 32'(load), 32'(m_pos == 1));
    chk("m_busy", 32'(busy), 32'(m_pos > 0));
    chk("m_done", 32'(frame_done), 32'(m_pos == SL + 1));
    chk("m_pin", 32'(parallel_in), 32'(m_data));
    chk("m_gidx", 32'(grant_idx), 32'(m_gidx));
    if (!rst) begin
      if (e_rdy != 0) begin
        m_pos = 1; m_gidx = win; m_last = win;
        m_data = req_data[8*win +: 8];
      end else if (m_pos == SL + 1) begin
        m_pos = 0;
      end else if (m_pos > 0) begin
        m_pos++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    chk("wait_idle", ok, 1);
  endtask

  int nld;
  int ld_cyc[8];
  logic [7:0] ld_dat[8];
  int ld_gid[8];

  task automatic collect(input int n, input int budget);
    nld = 0;
    for (int c = 0; c < budget && nld < n; c++) begin
      @(negedge clk);
      if (load) begin
        ld_cyc[nld] = c;
        ld_dat[nld] = parallel_in;
        ld_gid[nld] = int'(grant_idx);
        nld++;
      end
    end
    chk("collect_cnt", nld, n);
  endtask

  int nl, nb, fd_at, r1, coin, nfd, p;
  int l1_cyc[4];
  logic [7:0] l1_dat[4];
  logic [7:0] fair_exp[5];

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    v2 = 2'b11;
    d2 = {8'h5A, 8'hE1};

    repeat (3) step();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    step();
    rst = 1'b0;

    // SERIAL_LEN=1, two requesters always valid
    nl = 0; coin = 0; nfd = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (load2 && nl < 4) begin
        l1_cyc[nl] = k; l1_dat[nl] = pin2; nl++;
      end
      if (fd2) begin
        nfd++;
        if (rdy2 != 0) coin++;
      end
    end
    p = B2B ? 2 : 3;
    chk("sl1_nloads", nl, 4);
    for (int i = 0; i < 4; i++) begin
      chk("sl1_ldcyc", l1_cyc[i], 1 + i * p);
      chk("sl1_lddat", 32'(l1_dat[i]),
          (i % 2 == 0) ? 32'hE1 : 32'h5A);
    end
    chk("sl1_coin", coin, B2B ? nfd : 0);

    // single frame from requester 2
    step();
    req_valid = 4'b0100;
    req_data[23:16] = 8'h3C;
    @(negedge clk);
    chk("sf_grant", 32'(req_ready), 32'h4);
    nl = 0; nb = 0; fd_at = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) req_valid = '0;
      @(negedge clk);
      if (load) nl++;
      if (busy) nb++;
      if (frame_done) fd_at = k;
    end
    chk("sf_loads", nl, 1);
    chk("sf_busy", nb, 9);
    chk("sf_done_at", fd_at, 9);
    chk("sf_gidx", 32'(grant_idx), 2);
    chk("sf_pin", 32'(parallel_in), 32'h3C);

    // async reset in the middle of SHIFT
    step();
    req_valid = 4'b0010;
    req_data[15:8] = 8'h77;
    step();
    req_valid = '0;
    repeat (3) step();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_load", 32'(load), 0);
    chk("ar_pin", 32'(parallel_in), 0);
    chk("ar_ready", 32'(req_ready), 0);
    chk("ar_gidx", 32'(grant_idx), 0);
    chk("ar_done", 32'(frame_done), 0);
    req_valid = 4'b0001;
    req_data[7:0] = 8'hA5;
    step();
    step();
    @(negedge clk);
    chk("ar_hold_rdy", 32'(req_ready), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("ar_first_rdy", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("ar_load1", 32'(load), 1);
    chk("ar_pinA5", 32'(parallel_in), 32'hA5);
    wait_idle();

    // fairness with all requesters valid
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_data = 32'h4332_2110;
    req_valid = 4'b1111;
    collect(5, 80);
    fair_exp[0] = 8'h10; fair_exp[1] = 8'h21;
    fair_exp[2] = 8'h32; fair_exp[3] = 8'h43;
    fair_exp[4] = 8'h10;
    for (int i = 0; i < 5; i++) begin
      chk("fair_data", 32'(ld_dat[i]), 32'(fair_exp[i]));
      if (i > 0)
        chk("fair_gap", ld_cyc[i] - ld_cyc[i-1], B2B ? 9 : 10);
    end
    step();
    req_valid = '0;
    wait_idle();

    // wrap-around after a grant to requester 3
    step();
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    wait_idle();
    chk("rr_g3", 32'(grant_idx), 3);
    step();
    req_valid = 4'b1001;
    collect(2, 40);
    chk("rr_first", ld_gid[0], 0);
    chk("rr_second", ld_gid[1], 3);
    step();
    req_valid = '0;
    wait_idle();

    // request raised and dropped during SHIFT
    step();
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    step();
    r1 = 0; nl = 0;
    for (int k = 3; k <= 18; k++) begin
      step();
      if (k == 3) req_valid = 4'b0010;
      if (k == 6) req_valid = '0;
      @(negedge clk);
      if (req_ready[1]) r1++;
      if (load) nl++;
    end
    chk("drop_ready1", r1, 0);
    chk("drop_loads", nl, 0);
    chk("drop_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
